data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning consecutive arbitration losses by port 1 before it is forced to win (range 1..15).
REQ-002 SHALL have ports: clk  in  1  system clock, rising-edge active.
REQ-003 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: req0/req1  in  1  access request, CPU data port (0) and loader/debug port (1).
REQ-005 SHALL have ports: we0/we1  in  1  1=write, 0=read, qualified by reqN.
REQ-006 SHALL have ports: addr0/addr1  in  16  word address; wdata0/wdata1  in  16  write data.
REQ-007 SHALL have ports: gnt0/gnt1  out  1  one-cycle pulse, command issued to memory.
REQ-008 SHALL have ports: rvalid0/rvalid1  out  1  one-cycle pulse, read data valid; rdata0/rdata1  out  16  read data.
REQ-009 SHALL have ports: mem_wr_en, mem_rd_en  out  1; mem_addr, mem_wdata  out  16; mem_rdata  in  16 (memory read data valid one cycle after mem_rd_en).
REQ-010 SHALL have ports: busy  out  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, CMD, RDATA.
REQ-012 IDLE: if req0 or req1 sampled high, SHALL latch winner id, we, addr, wdata at the clock edge and go to CMD; else stay in IDLE.
REQ-013 CMD: SHALL drive mem_wr_en=latched we, mem_rd_en=~latched we, mem_addr/mem_wdata from latches, gntN=1 for the winner only; next state RDATA if read, else IDLE.
REQ-014 RDATA: SHALL drive rvalidN=1 for the latched winner and rdataN=mem_rdata; next state IDLE.
REQ-015 Latency: write = gnt 1 cycle after request sampled; read = rvalid 2 cycles after request sampled; max throughput one write per 2 cycles, one read per 3 cycles.
REQ-016 Requesters SHALL hold reqN/weN/addrN/wdataN stable until gntN; they drop reqN in the gnt cycle. The arbiter samples requests only in IDLE, so no request is ever issued twice.
REQ-017 All memory-side and gnt/rvalid outputs SHALL be zero outside the states above. rdataN SHALL be 0 when rvalidN=0.
REQ-018 Arbitration SHALL use fixed priority with port 0 winning ties (base behaviour; see REQ-023).
REQ-019 Simultaneous req0 and req1 in IDLE SHALL grant exactly one port. The loser's request SHALL remain pending and be re-arbitrated in the next IDLE.
REQ-020 A request deasserted before gnt SHALL be treated as withdrawn; this is illegal per REQ-016 and needs no recovery.

Reset
REQ-021 While rst=0, the block SHALL immediately force state=IDLE, all latches=0, starvation counter=0, and all outputs (gnt, rvalid, rdata, mem_wr_en, mem_rd_en, mem_addr, mem_wdata, busy)=0.
REQ-022 Reset asserted in CMD or RDATA SHALL abandon the transaction: no gnt or rvalid after release, and a write is not guaranteed to have reached memory.

Configuration
REQ-023 Macro ARB_STARVE_GUARD_EN defined: a 4-bit counter SHALL increment on each IDLE arbitration where req1=1 and port 0 wins. When counter==STARVE_MAX and req1=1, port 1 SHALL win regardless of req0. The counter SHALL clear when port 1 is granted.
REQ-024 Macro ARB_STARVE_GUARD_EN undefined: the counter logic SHALL be absent, and arbitration SHALL be pure fixed priority (port 0 can starve port 1 indefinitely).

Verification
REQ-025 Port 0 write of 0xBEEF to addr 0x0005 from IDLE -> gnt0 and mem_wr_en high one cycle later with mem_addr=0x0005 and mem_wdata=0xBEEF, then busy=0 the following cycle.
REQ-026 Port 1 read of addr 0x0003, with memory returning 0x1234 -> gnt1 at +1 cycle, rvalid1=1 and rdata1=0x1234 at +2 cycles, rvalid0 stays 0.
REQ-027 req0 and req1 both asserted in the same cycle (both reads) -> gnt0 first, then gnt1 exactly 3 cycles later, with no duplicate gnt to either port.
REQ-028 With ARB_STARVE_GUARD_EN and STARVE_MAX=4, req0 held continuously (re-asserting each transaction) and req1 held -> port 0 wins 4 arbitrations, port 1 wins the 5th, counter returns to 0. Without the macro, port 1 is never granted.
REQ-029 rst pulled low during the CMD of a read -> all outputs 0 immediately, no rvalid after release, next request is served normally from IDLE.

Source files
------------

// File: rtl/data_mem_arbiter.sv
`timescale 1ns/1ps
// Two-port (CPU data / loader-debug) arbiter in front of a single-ported data memory.
// Optional port-1 starvation guard is compiled in with ARB_STARVE_GUARD_EN.
module data_mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  // Handshake: reqN acts as valid and must hold with its command until gntN;
  // gntN is the one-cycle accept pulse, after which the requester drops reqN.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CMD   = 2'd1,
    S_RDATA = 2'd2
  } state_t;

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("STARVE_MAX must be in 1..15");
  end

  state_t      state_q, state_d;
  logic        win1_q, win1_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        pick1;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0]  starve_q, starve_d;

  always_comb begin
    pick1 = req1 & (~req0 | (starve_q == 4'(STARVE_MAX)));
  end
`else
  always_comb begin
    pick1 = req1 & ~req0;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      win1_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 16'h0000;
      wdata_q  <= 16'h0000;
`ifdef ARB_STARVE_GUARD_EN
      starve_q <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
      win1_q   <= win1_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
`ifdef ARB_STARVE_GUARD_EN
      starve_q <= starve_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    win1_d    = win1_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
`ifdef ARB_STARVE_GUARD_EN
    starve_d  = starve_q;
`endif
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rvalid0   = 1'b0;
    rvalid1   = 1'b0;
    rdata0    = 16'h0000;
    rdata1    = 16'h0000;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    busy      = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          win1_d  = pick1;
          we_d    = pick1 ? we1 : we0;
          addr_d  = pick1 ? addr1 : addr0;
          wdata_d = pick1 ? wdata1 : wdata0;
          state_d = S_CMD;
`ifdef ARB_STARVE_GUARD_EN
          // Losses only count while port 1 is actually waiting.
          if (pick1) begin
            starve_d = 4'd0;
          end else if (req1) begin
            starve_d = starve_q + 4'd1;
          end
`endif
        end
      end
      S_CMD: begin
        mem_wr_en = we_q;
        mem_rd_en = ~we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        gnt0      = ~win1_q;
        gnt1      = win1_q;
        state_d   = we_q ? S_IDLE : S_RDATA;
      end
      S_RDATA: begin
        rvalid0 = ~win1_q;
        rvalid1 = win1_q;
        rdata0  = win1_q ? 16'h0000 : mem_rdata;
        rdata1  = win1_q ? mem_rdata : 16'h0000;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
`timescale 1ns/1ps
// Bench for data_mem_arbiter: transaction-level reference model, directed cases and
// randomized two-port traffic against a small behavioural memory.
module tb_data_mem_arbiter;
  localparam int unsigned SM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic        mem_wr_en, mem_rd_en;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        busy;
  logic [1:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;

  data_mem_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- memory behind the arbiter ----------------
  function automatic logic [15:0] init_val(input int i);
    return (i == 3) ? 16'h1234 : (16'hA000 | 16'(i));
  endfunction

  logic [15:0] mem [16];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
    end else begin
      if (mem_wr_en) mem[mem_addr[3:0]] <= mem_wdata;
      if (mem_rd_en) mem_rdata <= mem[mem_addr[3:0]];
    end
  end

  // ---------------- reference model ----------------
  // sched[0] is what the outputs must be in the cycle following this edge,
  // sched[1]/[2] the cycles after that.
  typedef struct packed {
    logic        gnt0, gnt1, wr, rd;
    logic [15:0] addr, wdata;
    logic        rv0, rv1;
    logic [15:0] rd0, rd1;
    logic        busy;
  } exp_t;

  exp_t        sched [3];
  exp_t        cur = '0;
  exp_t        m_e;
  logic [15:0] model_mem [16];
  logic        m_prev, m_w1, m_we;
  logic [15:0] m_a, m_d;
  int unsigned losses = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) sched[i] = '0;
      for (int i = 0; i < 16; i++) model_mem[i] = init_val(i);
      cur = '0;
      losses = 0;
    end else begin
      m_prev = sched[0].busy;
      sched[0] = sched[1];
      sched[1] = sched[2];
      sched[2] = '0;
      if (!m_prev && (req0 || req1)) begin
`ifdef ARB_STARVE_GUARD_EN
        m_w1 = req1 && (!req0 || losses == SM);
`else
        m_w1 = req1 && !req0;
`endif
        if (m_w1) losses = 0;
        else if (req1) losses++;
        m_we = m_w1 ? we1 : we0;
        m_a  = m_w1 ? addr1 : addr0;
        m_d  = m_w1 ? wdata1 : wdata0;
        m_e = '0;
        m_e.busy = 1'b1; m_e.gnt0 = !m_w1; m_e.gnt1 = m_w1;
        m_e.wr = m_we; m_e.rd = !m_we; m_e.addr = m_a; m_e.wdata = m_d;
        sched[0] = m_e;
        if (m_we) begin
          model_mem[m_a[3:0]] = m_d;
        end else begin
          m_e = '0;
          m_e.busy = 1'b1;
          if (m_w1) begin m_e.rv1 = 1'b1; m_e.rd1 = model_mem[m_a[3:0]]; end
          else      begin m_e.rv0 = 1'b1; m_e.rd0 = model_mem[m_a[3:0]]; end
          sched[1] = m_e;
        end
      end
      cur = sched[0];
    end
  end

  // ---------------- every-cycle compare ----------------
  always @(negedge clk) begin
    chk("gnt0",      32'(gnt0),      32'(cur.gnt0));
    chk("gnt1",      32'(gnt1),      32'(cur.gnt1));
    chk("mem_wr_en", 32'(mem_wr_en), 32'(cur.wr));
    chk("mem_rd_en", 32'(mem_rd_en), 32'(cur.rd));
    chk("mem_addr",  32'(mem_addr),  32'(cur.addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
    chk("rvalid0",   32'(rvalid0),   32'(cur.rv0));
    chk("rvalid1",   32'(rvalid1),   32'(cur.rv1));
    chk("rdata0",    32'(rdata0),    32'(cur.rd0));
    chk("rdata1",    32'(rdata1),    32'(cur.rd1));
    chk("busy",      32'(busy),      32'(cur.busy));
    chk("state_dbg_busy", 32'(state_dbg != 2'd0), 32'(cur.busy));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    if (gnt0) req0 = 1'b0;
    if (gnt1) req1 = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((req0 || req1 || busy) && k < 60) begin
      tick();
      k++;
    end
    chk("drain_timeout", 32'(req0 || req1 || busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int ng, f1, s1, g0_at, g1_at, g0n, g1n;
  int unsigned p0, p1;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_gnt0",  32'(gnt0), 32'd0);
    chk("rst_maddr", 32'(mem_addr), 32'd0);
    rst = 1'b1;
    tick();

    // Port 0 write 0xBEEF -> addr 5
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0005; wdata0 = 16'hBEEF;
    tick();
    chk("w_gnt0",  32'(gnt0), 32'd1);
    chk("w_wr_en", 32'(mem_wr_en), 32'd1);
    chk("w_addr",  32'(mem_addr), 32'h0005);
    chk("w_wdata", 32'(mem_wdata), 32'hBEEF);
    tick();
    chk("w_busy_after", 32'(busy), 32'd0);

    // Port 1 read of addr 3
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0003;
    tick();
    chk("r_gnt1",  32'(gnt1), 32'd1);
    chk("r_rd_en", 32'(mem_rd_en), 32'd1);
    tick();
    chk("r_rvalid1", 32'(rvalid1), 32'd1);
    chk("r_rdata1",  32'(rdata1), 32'h1234);
    chk("r_rvalid0", 32'(rvalid0), 32'd0);
    wait_idle();

    // Simultaneous reads
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0001;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0002;
    g0_at = -1; g1_at = -1; g0n = 0; g1n = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (gnt0) begin g0n++; if (g0_at < 0) g0_at = k; end
      if (gnt1) begin g1n++; if (g1_at < 0) g1_at = k; end
    end
    chk("tie_gnt0_at", 32'(g0_at), 32'd0);
    chk("tie_gnt1_at", 32'(g1_at), 32'd3);
    chk("tie_gnt0_n",  32'(g0n), 32'd1);
    chk("tie_gnt1_n",  32'(g1n), 32'd1);
    wait_idle();

    // Port 0 hammering writes while port 1 waits on reads
    ng = 0; f1 = -1; s1 = -1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0007;
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0008; wdata0 = 16'h0F0F;
    for (int k = 0; k < 60 && ng < 10; k++) begin
      tick();
      if (gnt1) begin
        if (f1 < 0) f1 = ng;
        else if (s1 < 0) s1 = ng;
      end
      if (gnt0 || gnt1) ng++;
      if (!req0 && !gnt0 && ng < 10) begin
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'(8 + (k % 4)); wdata0 = 16'($urandom);
      end
      if (!req1 && !gnt1 && ng < 10) begin
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0007;
      end
    end
    chk("starve_grants", 32'(ng), 32'd10);
`ifdef ARB_STARVE_GUARD_EN
    chk("starve_first_p1",  32'(f1), 32'd4);
    chk("starve_second_p1", 32'(s1), 32'd9);
`else
    chk("starve_p1_never", 32'(f1), 32'hFFFF_FFFF);
`endif
    wait_idle();

    // Reset during CMD of a read, then a normal read after release
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0004;
    tick();
    chk("rc_gnt0",  32'(gnt0), 32'd1);
    chk("rc_rd_en", 32'(mem_rd_en), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rc_gnt0_low",  32'(gnt0), 32'd0);
    chk("rc_rd_en_low", 32'(mem_rd_en), 32'd0);
    chk("rc_addr_low",  32'(mem_addr), 32'd0);
    chk("rc_busy_low",  32'(busy), 32'd0);
    tick();
    tick();
    #2 rst = 1'b1;
    tick();
    chk("rc_no_rvalid", 32'(rvalid0), 32'd0);
    chk("rc_idle",      32'(busy), 32'd0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0005;
    tick();
    chk("rc2_gnt0", 32'(gnt0), 32'd1);
    tick();
    chk("rc2_rvalid0", 32'(rvalid0), 32'd1);
    chk("rc2_rdata0",  32'(rdata0), 32'hA005);
    wait_idle();

    // Randomized two-port traffic
    p0 = 50; p1 = 50;
    for (int k = 0; k < 2000; k++) begin
      tick();
      if (k % 250 == 0) begin
        p0 = $urandom_range(20, 100);
        p1 = $urandom_range(10, 100);
      end
      if (!req0 && !gnt0 && $urandom_range(0, 99) < p0) begin
        req0 = 1'b1; we0 = 1'($urandom_range(0, 1));
        addr0 = 16'($urandom_range(0, 15)); wdata0 = 16'($urandom);
      end
      if (!req1 && !gnt1 && $urandom_range(0, 99) < p1) begin
        req1 = 1'b1; we1 = 1'($urandom_range(0, 1));
        addr1 = 16'($urandom_range(0, 15)); wdata1 = 16'($urandom);
      end
    end
    wait_idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
